// File: rtl/markov_pkg.sv
// Shared definitions for the Markov learner / sequence generator pair:
// default widths, generator state encoding, LFSR constants and the
// {row, col} transition-table address packing.
package markov_pkg;

  localparam int SYM_W_DEF  = 3;
  localparam int CNT_W_DEF  = 8;
  localparam int LFSR_W_DEF = 16;
  localparam int LEN_W_DEF  = 8;

  // Galois feedback mask and the value used whenever a zero seed is supplied
  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUM  = 3'd1,
    ST_DRAW = 3'd2,
    ST_SCAN = 3'd3,
    ST_EMIT = 3'd4,
    ST_DONE = 3'd5
  } gen_state_t;

  // Table address: row is the current symbol, column the candidate successor
  function automatic logic [2*SYM_W_DEF-1:0] tbl_addr(input logic [SYM_W_DEF-1:0] row,
                                                     input logic [SYM_W_DEF-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/markov_lfsr.sv
// Right-shifting Galois LFSR with synchronous load and step enable.
// A zero load value is replaced by SEED so the register never locks up.
module markov_lfsr
  import markov_pkg::*;
#(
  parameter int           W    = LFSR_W_DEF,
  parameter logic [W-1:0] MASK = W'(LFSR_MASK),
  parameter logic [W-1:0] SEED = W'(LFSR_SEED_DEF)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] value
);

  // Load has priority over step; one Galois shift per enabled cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (load) begin
      value <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      value <= (value >> 1) ^ (value[0] ? MASK : '0);
    end
  end

endmodule

// File: rtl/markov_sequence_generator.sv
// Markov sequence generator: reads the transition-count table row of the
// current symbol, draws a count-weighted successor and streams it out.
// Optional feature macro: MARKOV_GEN_RESTART_EN (restart from the captured
// first symbol on an all-zero row instead of terminating).
// Stream handshake: sym_valid is high only in EMIT and sym_data is stable
// while it is high; a symbol transfers on a rising edge with
// sym_valid && sym_ready, and sym_valid never drops before that except on reset.
module markov_sequence_generator
  import markov_pkg::*;
#(
  parameter int SYM_W  = SYM_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LFSR_W = LFSR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LFSR_W-1:0]  seed,
  input  logic [SYM_W-1:0]   first_sym,
  input  logic [LEN_W-1:0]   seq_len,
  output logic               tbl_rd_en,
  output logic [2*SYM_W-1:0] tbl_rd_addr,
  input  logic [CNT_W-1:0]   tbl_rd_data,
  output logic               sym_valid,
  output logic [SYM_W-1:0]   sym_data,
  input  logic               sym_ready,
  output logic               busy,
  output logic               done,
  output logic               dead_end,
  output gen_state_t         state_dbg
);

  localparam int TOT_W = CNT_W + SYM_W;
  localparam int PW    = LFSR_W + TOT_W;
  localparam logic [SYM_W:0] NSYM_C  = {1'b1, {SYM_W{1'b0}}};
  localparam logic [SYM_W:0] COL_ONE = {{SYM_W{1'b0}}, 1'b1};

  gen_state_t        state_q, state_d;
  logic [SYM_W-1:0]  cur_q;
  logic [SYM_W-1:0]  sym_q;
  logic [LEN_W-1:0]  rem_q;
  logic [SYM_W:0]    col_q;      // next column to issue; reaches NSYM after the last read
  logic              pend_q;     // a read was issued last cycle, so tbl_rd_data is valid now
  logic [TOT_W-1:0]  total_q, cum_q, r_q;
  logic              dead_q;
  logic [LFSR_W-1:0] lfsr_val;

  logic             accept, issue, sum_last, zero_row, hit, restart, col_clr;
  logic [TOT_W-1:0] sum_next, cum_next, draw_r;
  logic [PW-1:0]    prod;

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign issue    = (col_q < NSYM_C);
  assign sum_next = total_q + TOT_W'(tbl_rd_data);
  assign cum_next = cum_q + TOT_W'(tbl_rd_data);
  assign sum_last = (state_q == ST_SUM) && (col_q == NSYM_C);
  assign zero_row = sum_last && (sum_next == '0);
  // The first column whose running sum exceeds r wins; zero-weight columns never do
  assign hit      = (state_q == ST_SCAN) && pend_q && (cum_next > r_q);
  // Full-width product keeps r in [0, total-1]
  assign prod     = PW'(lfsr_val) * PW'(total_q);
  assign draw_r   = TOT_W'(prod >> LFSR_W);
  assign col_clr  = (state_d != state_q) || sum_last;

`ifdef MARKOV_GEN_RESTART_EN
  logic [SYM_W-1:0] first_q;
  assign restart = zero_row && (cur_q != first_q);
`else
  assign restart = 1'b0;
`endif

  markov_lfsr #(
    .W    (LFSR_W),
    .MASK (LFSR_W'(LFSR_MASK)),
    .SEED (LFSR_W'(LFSR_SEED_DEF))
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (seed),
    .step     (state_q == ST_DRAW),
    .value    (lfsr_val)
  );

  // Next-state and table read strobe
  always_comb begin
    state_d   = state_q;
    tbl_rd_en = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (seq_len == '0) ? ST_DONE : ST_SUM;
      end
      ST_SUM: begin
        tbl_rd_en = issue;
        if (sum_last) begin
          if (sum_next != '0) state_d = ST_DRAW;
          else if (restart)   state_d = ST_SUM;
          else                state_d = ST_DONE;
        end
      end
      ST_DRAW: state_d = ST_SCAN;
      ST_SCAN: begin
        tbl_rd_en = issue && !hit;
        if (hit) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (sym_ready) state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_SUM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: column counter, accumulators, draw value, symbol and sequence bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      pend_q  <= 1'b0;
      total_q <= '0;
      cum_q   <= '0;
      r_q     <= '0;
      sym_q   <= '0;
      cur_q   <= '0;
      rem_q   <= '0;
      dead_q  <= 1'b0;
`ifdef MARKOV_GEN_RESTART_EN
      first_q <= '0;
`endif
    end else begin
      pend_q <= tbl_rd_en;
      if (col_clr)        col_q <= '0;
      else if (tbl_rd_en) col_q <= col_q + COL_ONE;
      if (state_q == ST_SUM)  total_q <= pend_q ? sum_next : '0;
      if (state_q == ST_SCAN) cum_q   <= pend_q ? cum_next : '0;
      if (state_q == ST_DRAW) r_q     <= draw_r;
      if (hit) sym_q <= col_q[SYM_W-1:0] - SYM_W'(1);
      if (accept) begin
        cur_q <= first_sym;
        rem_q <= seq_len;
`ifdef MARKOV_GEN_RESTART_EN
        first_q <= first_sym;
`endif
      end else if ((state_q == ST_EMIT) && sym_ready) begin
        cur_q <= sym_q;
        rem_q <= rem_q - LEN_W'(1);
      end
`ifdef MARKOV_GEN_RESTART_EN
      else if (restart) begin
        cur_q <= first_q;
      end
`endif
      if (accept)        dead_q <= 1'b0;
      else if (zero_row) dead_q <= 1'b1;
`ifdef MARKOV_GEN_RESTART_EN
      else if (state_q == ST_SUM) dead_q <= 1'b0;
`endif
    end
  end

  assign tbl_rd_addr = {cur_q, col_q[SYM_W-1:0]};
  assign sym_valid   = (state_q == ST_EMIT);
  assign sym_data    = sym_q;
  assign busy        = (state_q == ST_SUM) || (state_q == ST_DRAW) ||
                       (state_q == ST_SCAN) || (state_q == ST_EMIT);
  assign done        = (state_q == ST_DONE);
  assign dead_end    = dead_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_markov_sequence_generator.sv
// Directed bench for markov_sequence_generator: vector table of
// {first symbol, length, seed, expected symbols, expected dead end}, plus
// hand-written stall, distribution and reset-abort sequences.
module tb_markov_sequence_generator;
  import markov_pkg::*;

  localparam int NSYM = 8;

  logic       clk = 1'b0;
  logic       reset, start, sym_ready;
  logic [15:0] seed;
  logic [2:0]  first_sym;
  logic [7:0]  seq_len;
  logic        tbl_rd_en;
  logic [5:0]  tbl_rd_addr;
  logic [7:0]  tbl_rd_data;
  logic        sym_valid;
  logic [2:0]  sym_data;
  logic        busy, done, dead_end;
  gen_state_t  state_dbg;

  logic [7:0] mem [64];

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] exp_q[$];
  logic [2:0] out_q[$];
  int         hs_q[$];
  int         rd_cnt, fin_idx;
  bit         timed_out;
  logic       b1, r1, d1;

  typedef struct {
    logic [2:0]  f;
    logic [7:0]  len;
    logic [15:0] s;
    bit          rnd;
    int          n;
    logic [23:0] syms;
    bit          dead;
  } vec_t;
  vec_t vt [8];

  // clock / table memory with one-cycle read latency
  always #5 clk = ~clk;
  always @(posedge clk) if (tbl_rd_en) tbl_rd_data <= mem[tbl_rd_addr];

  markov_sequence_generator dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .first_sym(first_sym),
    .seq_len(seq_len), .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr),
    .tbl_rd_data(tbl_rd_data), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .busy(busy), .done(done), .dead_end(dead_end),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference draw model straight from the weighting formula
  function automatic void model_run(input logic [2:0] f, input int len, input logic [15:0] s);
    logic [15:0] lf;
    logic [2:0]  cur;
    logic [31:0] prod;
    int total, cum, k, r;
    lf = (s == 16'h0) ? 16'hACE1 : s;
    cur = f;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      total = 0;
      for (int c = 0; c < NSYM; c++) total += int'(mem[{cur, 3'(c)}]);
      if (total == 0) break;
      prod = 32'(lf) * 32'(total);
      r = int'(prod >> 16);
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
      cum = 0;
      k = 0;
      for (int c = 0; c < NSYM; c++) begin
        cum += int'(mem[{cur, 3'(c)}]);
        if (cum > r) begin k = c; break; end
      end
      exp_q.push_back(3'(k));
      cur = 3'(k);
    end
  endfunction

  // Start a sequence and collect handshakes; idx counts negedges after the start edge
  task automatic run_seq(input logic [2:0] f, input logic [7:0] len, input logic [15:0] s,
                         input bit rnd, input int max_cyc);
    out_q.delete(); hs_q.delete();
    rd_cnt = 0; timed_out = 1'b1; fin_idx = 0;
    @(negedge clk);
    start = 1'b1; first_sym = f; seq_len = len; seed = s; sym_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int idx = 1; idx <= max_cyc; idx++) begin
      if (idx == 1) begin b1 = busy; r1 = tbl_rd_en; d1 = done; end
      if (done) begin timed_out = 1'b0; fin_idx = idx; break; end
      sym_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tbl_rd_en) rd_cnt++;
      if (sym_valid && sym_ready) begin
        out_q.push_back(sym_data);
        hs_q.push_back(idx);
      end
      @(negedge clk);
    end
    sym_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    int rd_exp, n6, nother, ntot;
    bit got;
    reset = 1'b1; start = 1'b0; sym_ready = 1'b1;
    seed = '0; first_sym = '0; seq_len = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'd0;
    mem[{3'd2, 3'd5}] = 8'd7;
    mem[{3'd5, 3'd2}] = 8'd3;
    mem[{3'd4, 3'd7}] = 8'd2;
    mem[{3'd7, 3'd0}] = 8'd5;

    vt[0] = '{f:3'd2, len:8'd4, s:16'h0001, rnd:1'b0, n:4, syms:{12'd0, 3'd2, 3'd5, 3'd2, 3'd5}, dead:1'b0};
    vt[1] = '{f:3'd2, len:8'd0, s:16'h0002, rnd:1'b0, n:0, syms:24'd0, dead:1'b0};
    vt[2] = '{f:3'd1, len:8'd3, s:16'h0003, rnd:1'b0, n:0, syms:24'd0, dead:1'b1};
    vt[3] = '{f:3'd5, len:8'd3, s:16'h0004, rnd:1'b1, n:3, syms:{15'd0, 3'd2, 3'd5, 3'd2}, dead:1'b0};
    vt[4] = '{f:3'd4, len:8'd2, s:16'h0000, rnd:1'b0, n:2, syms:{18'd0, 3'd0, 3'd7}, dead:1'b0};
    vt[5] = '{f:3'd7, len:8'd3, s:16'h0005, rnd:1'b0, n:1, syms:{21'd0, 3'd0}, dead:1'b1};
    vt[6] = '{f:3'd2, len:8'd4, s:16'h0006, rnd:1'b1, n:4, syms:{12'd0, 3'd2, 3'd5, 3'd2, 3'd5}, dead:1'b0};
    vt[7] = '{f:3'd3, len:8'd1, s:16'h0007, rnd:1'b0, n:0, syms:24'd0, dead:1'b1};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dead_end", dead_end, 0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_data", sym_data, 0);
    check("rst_rd_en", tbl_rd_en, 0);
    check("rst_rd_addr", tbl_rd_addr, 0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b0;

    // table-driven vectors
    for (int v = 0; v < 8; v++) begin
      run_seq(vt[v].f, vt[v].len, vt[v].s, vt[v].rnd, 400);
      check($sformatf("v%0d_timeout", v), timed_out, 0);
      if (timed_out) begin pulse_reset(); continue; end
      check($sformatf("v%0d_count", v), out_q.size(), vt[v].n);
      rd_exp = vt[v].dead ? NSYM : 0;
      for (int i = 0; i < vt[v].n; i++) begin
        rd_exp += NSYM + int'(vt[v].syms[3*i +: 3]) + 1;
        if (i < out_q.size())
          check($sformatf("v%0d_sym%0d", v, i), out_q[i], vt[v].syms[3*i +: 3]);
      end
      check($sformatf("v%0d_reads", v), rd_cnt, rd_exp);
      check($sformatf("v%0d_dead_end", v), dead_end, vt[v].dead);
      check($sformatf("v%0d_done", v), done, 1);
      check($sformatf("v%0d_busy_end", v), busy, 0);
      check($sformatf("v%0d_valid_end", v), sym_valid, 0);
      if (vt[v].len == 8'd0) begin
        check($sformatf("v%0d_done_t1", v), d1, 1);
        check($sformatf("v%0d_busy_t1", v), b1, 0);
      end else begin
        check($sformatf("v%0d_busy_t1", v), b1, 1);
        check($sformatf("v%0d_rd_en_t1", v), r1, 1);
      end
      if (vt[v].dead && vt[v].n == 0)
        check($sformatf("v%0d_sum_len", v), fin_idx, NSYM + 2);
      if (!vt[v].rnd && vt[v].n > 0 && hs_q.size() == vt[v].n) begin
        check($sformatf("v%0d_first_lat", v), hs_q[0], int'(vt[v].syms[2:0]) + 13);
        for (int i = 1; i < vt[v].n; i++)
          check($sformatf("v%0d_gap%0d", v, i), hs_q[i] - hs_q[i-1],
                NSYM + int'(vt[v].syms[3*i +: 3]) + 5);
        if (!vt[v].dead)
          check($sformatf("v%0d_done_lat", v), fin_idx, hs_q[vt[v].n-1] + 1);
      end
      repeat (2) @(negedge clk);
    end

    // consumer stall in EMIT with an ignored start
    @(negedge clk);
    sym_ready = 1'b0; start = 1'b1; first_sym = 3'd2; seq_len = 8'd2; seed = 16'h0042;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sym_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("stall_valid_seen", got, 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall_valid%0d", i), sym_valid, 1);
      check($sformatf("stall_data%0d", i), sym_data, 3'd5);
      start = (i == 3); first_sym = 3'd4; seq_len = 8'd1;
      @(negedge clk);
    end
    start = 1'b0; sym_ready = 1'b1;
    out_q.delete();
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      if (sym_valid) out_q.push_back(sym_data);
      @(negedge clk);
    end
    check("stall_done", done, 1);
    check("stall_count", out_q.size(), 2);
    if (out_q.size() == 2) begin
      check("stall_sym0", out_q[0], 3'd5);
      check("stall_sym1", out_q[1], 3'd2);
    end

    // weighted draw distribution: every row = {col1:1, col6:3}
    for (int i = 0; i < 64; i++) mem[i] = 8'd0;
    for (int r = 0; r < NSYM; r++) begin
      mem[{3'(r), 3'd1}] = 8'd1;
      mem[{3'(r), 3'd6}] = 8'd3;
    end
    n6 = 0; nother = 0; ntot = 0;
    for (int run = 0; run < 8; run++) begin
      run_seq(3'(run), 8'd250, 16'h1234 + 16'(run), 1'b0, 6000);
      check($sformatf("freq%0d_timeout", run), timed_out, 0);
      if (timed_out) begin pulse_reset(); continue; end
      model_run(3'(run), 250, 16'h1234 + 16'(run));
      check($sformatf("freq%0d_count", run), out_q.size(), exp_q.size());
      for (int i = 0; i < out_q.size(); i++) begin
        if (i < exp_q.size()) check($sformatf("freq%0d_sym%0d", run, i), out_q[i], exp_q[i]);
        ntot++;
        if (out_q[i] == 3'd6) n6++;
        else if (out_q[i] != 3'd1) nother++;
      end
    end
    check("freq_total", ntot, 2000);
    check("freq_other_syms", nother, 0);
    check("freq_col6_in_range", (n6 * 100 >= 72 * ntot) && (n6 * 100 <= 78 * ntot), 1);

    // reset during SCAN, then a clean rerun with the same (zero) seed
    @(negedge clk);
    start = 1'b1; first_sym = 3'd0; seq_len = 8'd6; seed = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("abort_in_scan", state_dbg, ST_SCAN);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dead_end", dead_end, 0);
    check("abort_sym_valid", sym_valid, 0);
    check("abort_sym_data", sym_data, 0);
    check("abort_rd_en", tbl_rd_en, 0);
    check("abort_rd_addr", tbl_rd_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    run_seq(3'd0, 8'd6, 16'h0000, 1'b0, 400);
    check("rerun_timeout", timed_out, 0);
    model_run(3'd0, 6, 16'h0000);
    check("rerun_count", out_q.size(), 6);
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check($sformatf("rerun_sym%0d", i), out_q[i], exp_q[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
